// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The MUX_SEL encoding is also used by the TX output multiplexer.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_IDLE  = 2'b11;

  // Mux select the line carries while the FSM sits in a given state.
  function automatic logic [1:0] sel_of(tx_state_e s);
    case (s)
      START:   sel_of = SEL_START;
      DATA:    sel_of = SEL_DATA;
      PARITY:  sel_of = SEL_PAR;
      default: sel_of = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter.
// done flags the final data bit so the FSM can leave DATA on that tick.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ser_data,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= din;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  assign ser_data = shift_reg[0];
  assign done     = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit control: accepts a byte, sequences start/data/parity/stop
// and presents the mux select for the bit the line carries after the next tick.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            MUX_SEL,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  tx_state_e state;
  logic      par_en_q;
  logic      load, shift, done;

  // Accept ignores TX_tick, so a tick coinciding with accept is not the start bit.
  assign load  = (state == IDLE) && DATA_VALID;
  assign shift = (state == DATA) && TX_tick;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift    (shift),
    .din      (P_DATA),
    .ser_data (ser_data),
    .done     (done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      MUX_SEL  <= SEL_IDLE;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (DATA_VALID) begin
          state    <= START;
          MUX_SEL  <= sel_of(START);
          par_en_q <= PAR_EN;
          par_bit  <= ^P_DATA ^ PAR_TYP;
          busy     <= 1'b1;
        end
        START: if (TX_tick) begin
          state   <= DATA;
          MUX_SEL <= sel_of(DATA);
        end
        DATA: if (TX_tick && done) begin
          state   <= par_en_q ? PARITY : STOP;
          MUX_SEL <= par_en_q ? sel_of(PARITY) : sel_of(STOP);
        end
        PARITY: if (TX_tick) begin
          state   <= STOP;
          MUX_SEL <= sel_of(STOP);
        end
        STOP: if (TX_tick) begin
          state   <= IDLE;
          MUX_SEL <= sel_of(IDLE);
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          MUX_SEL <= SEL_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a tick-counting frame model queues the
// expected line bits; a monitor emulates the output mux and compares per tick.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST, TX_tick, DATA_VALID, PAR_EN, PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic [1:0]    MUX_SEL;
  logic          ser_data, par_bit, busy;

  typedef struct {
    logic [1:0] sel;
    logic       b;
  } line_t;

  line_t exp_q[$];
  int    rem = 0, acc_cnt = 0, checks = 0, failures = 0;
  int    tick_per = 4, tick_cnt = 0;
  logic  last_par = 1'b0;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TX_tick    (TX_tick),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .MUX_SEL    (MUX_SEL),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Whole frame as seen on the line: start 0, data LSB first, optional parity, stop 1.
  task automatic push_frame(logic [DW-1:0] d, logic pe, logic pt);
    line_t it;
    int    ones = 0;
    for (int i = 0; i < DW; i++) ones += d[i];
    it.sel = 2'b00; it.b = 1'b0; exp_q.push_back(it);
    for (int i = 0; i < DW; i++) begin
      it.sel = 2'b01; it.b = d[i]; exp_q.push_back(it);
    end
    last_par = (ones % 2 == 1) ? ~pt : pt;
    if (pe) begin
      it.sel = 2'b10; it.b = last_par; exp_q.push_back(it);
    end
    it.sel = 2'b11; it.b = 1'b1; exp_q.push_back(it);
    rem = 2 + DW + (pe ? 1 : 0);
    acc_cnt++;
  endtask

  // Tick generator: one-CLK strobe every tick_per cycles.
  initial begin
    TX_tick = 1'b0;
    forever begin
      @(posedge CLK); #1;
      tick_cnt++;
      if (tick_cnt >= tick_per) begin
        tick_cnt = 0;
        TX_tick  = 1'b1;
      end else TX_tick = 1'b0;
    end
  end

  // Monitor + model: inputs are stable at negedge and are what the next edge sees.
  initial begin
    line_t it;
    logic  line, idle_pre;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("rst_sel", MUX_SEL, 2'b11);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ser", ser_data, 1'b0);
        chk("rst_par", par_bit, 1'b0);
        exp_q.delete();
        rem = 0;
        last_par = 1'b0;
      end else begin
        idle_pre = (rem == 0);
        chk("busy", busy, !idle_pre);
        chk("par_hold", par_bit, last_par);
        if (TX_tick) begin
          if (!idle_pre) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL underflow at %0t: got busy tick, expected nothing queued", $time);
            end else begin
              it = exp_q.pop_front();
              case (MUX_SEL)
                SEL_START: line = 1'b0;
                SEL_DATA:  line = ser_data;
                SEL_PAR:   line = par_bit;
                default:   line = 1'b1;
              endcase
              chk("tick_sel", MUX_SEL, it.sel);
              chk("tick_line", line, it.b);
            end
            rem--;
          end else chk("idle_sel", MUX_SEL, 2'b11);
        end
        if (idle_pre && DATA_VALID) push_frame(P_DATA, PAR_EN, PAR_TYP);
      end
    end
  end

  task automatic wait_idle(int lim);
    int n = 0;
    while (rem != 0 && n < lim) begin
      @(posedge CLK); #1;
      n++;
    end
    if (rem != 0) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout: got rem=%0d expected 0", rem);
    end
  endtask

  task automatic send(logic [DW-1:0] d, logic pe, logic pt);
    wait_idle(500);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
  endtask

  initial begin
    int n, a0;
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (10) @(posedge CLK);
    #1;

    send(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b0);

    // Request during a frame is dropped; a held request lands right after STOP.
    send(8'hFF, 1'b1, 1'b0);
    n = 0;
    while (exp_q.size() > 7 && n < 200) begin @(posedge CLK); #1; n++; end
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    a0 = acc_cnt; n = 0;
    while (acc_cnt == a0 && n < 500) begin @(posedge CLK); #1; n++; end
    if (acc_cnt == a0) begin
      checks++; failures++;
      $display("FAIL held_accept timeout: got no accept expected one");
    end
    DATA_VALID = 1'b0;
    wait_idle(500);

    // Accept coinciding with a tick.
    n = 0;
    while (TX_tick !== 1'b1 && n < 50) begin @(posedge CLK); #2; n++; end
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    wait_idle(500);

    // Asynchronous reset after the third data tick.
    send(8'hA5, 1'b1, 1'b0);
    n = 0;
    while (exp_q.size() > 7 && n < 200) begin @(posedge CLK); #3; n++; end
    RST = 1'b0;
    #1;
    chk("async_sel", MUX_SEL, 2'b11);
    chk("async_busy", busy, 1'b0);
    chk("async_ser", ser_data, 1'b0);
    chk("async_par", par_bit, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;

    // Random traffic, tick rates and parity settings.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) tick_per = $urandom_range(2, 5);
      DATA_VALID = ($urandom % 6 == 0);
      P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      @(posedge CLK); #1;
    end
    DATA_VALID = 1'b0;
    wait_idle(500);
    repeat (10) @(posedge CLK);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
